// File: rtl/stream_frame_sched.sv
`timescale 1ns/1ps
// stream_frame_sched: whole-frame gate in front of the sensor stream path.
// Continuous or burst forwarding; start/stop only ever take effect at fval edges.
module stream_frame_sched #(
  parameter int DATA_WIDTH  = 10,
  parameter int CHANNEL_NUM = 1,
  parameter int REG_WD      = 32
) (
  input  logic                              clk_sensor_pix,
  input  logic                              reset_n,
  input  logic                              i_fval,
  input  logic                              i_lval,
  input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  input  logic                              i_stream_enable,
  input  logic                              i_acquisition_start,
  input  logic                              i_encrypt_state,
  input  logic                              i_burst_mode,
  input  logic [REG_WD-1:0]                 iv_burst_num,
  input  logic                              i_trigger,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                              o_full_frame_state,
  output logic [REG_WD-1:0]                 ov_frame_cnt,
  output logic [REG_WD-1:0]                 ov_burst_remain
);
  localparam int PW = DATA_WIDTH * CHANNEL_NUM;
  typedef enum logic [1:0] {IDLE, ARMED, PASS} state_t;
  state_t state_q, state_d;
  logic fval_dly_q;
  logic mode_q, mode_d;
  logic [REG_WD-1:0] frame_cnt_q, frame_cnt_d, burst_remain_q, burst_remain_d;
  logic o_fval_q, o_fval_d, o_lval_q, o_lval_d;
  logic [PW-1:0] pix_q, pix_d;
  logic en, rise, fall, pass;
  assign en   = i_stream_enable & i_acquisition_start & i_encrypt_state;
  assign rise = i_fval & ~fval_dly_q;
  assign fall = ~i_fval & fval_dly_q;
  // A frame is only passed if its rising edge is seen while already armed.
  assign pass = (state_q == PASS) | ((state_q == ARMED) & en & rise);
  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    frame_cnt_d    = frame_cnt_q;
    burst_remain_d = burst_remain_q;
    case (state_q)
      IDLE:
        if (en && !i_burst_mode) begin
          state_d        = ARMED;
          mode_d         = 1'b0;
          burst_remain_d = '0;
        end else if (en && i_trigger && iv_burst_num != '0) begin
          state_d        = ARMED;
          mode_d         = 1'b1;
          burst_remain_d = iv_burst_num;
        end
      ARMED:
        if (!en) begin
          state_d        = IDLE;
          burst_remain_d = '0;
        end else if (rise) state_d = PASS;
      PASS:
        if (fall) begin
          frame_cnt_d    = frame_cnt_q + REG_WD'(1);
          burst_remain_d = mode_q ? burst_remain_q - REG_WD'(1) : burst_remain_q;
          state_d        = (!en || (mode_q && burst_remain_q == REG_WD'(1))) ? IDLE : ARMED;
        end
      default: state_d = IDLE;
    endcase
    o_fval_d = i_fval & pass;
    o_lval_d = i_lval & pass & i_fval;
    pix_d    = pass ? iv_pix_data : '0;
  end
  always_ff @(posedge clk_sensor_pix or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      fval_dly_q     <= 1'b0;
      mode_q         <= 1'b0;
      frame_cnt_q    <= '0;
      burst_remain_q <= '0;
      o_fval_q       <= 1'b0;
      o_lval_q       <= 1'b0;
      pix_q          <= '0;
    end else begin
      state_q        <= state_d;
      fval_dly_q     <= i_fval;
      mode_q         <= mode_d;
      frame_cnt_q    <= frame_cnt_d;
      burst_remain_q <= burst_remain_d;
      o_fval_q       <= o_fval_d;
      o_lval_q       <= o_lval_d;
      pix_q          <= pix_d;
    end
  end
  assign o_fval             = o_fval_q;
  assign o_lval             = o_lval_q;
  assign ov_pix_data        = pix_q;
  assign o_full_frame_state = o_fval_q;
  assign ov_frame_cnt       = frame_cnt_q;
  assign ov_burst_remain    = burst_remain_q;
endmodule

// File: doc/stream_frame_sched.md
Name: stream_frame_sched

Overview:
- Frame-level scheduler in front of the sensor stream path (sensor_if/stream_sync). It decides which sensor frames are forwarded downstream, based on the stream-enable, acquisition-start and encrypt qualifiers plus a continuous/burst acquisition mode.
- Only whole frames are forwarded. Start and stop take effect only at fval edges, so the downstream sync buffer never sees a truncated frame.

Parameters:
- DATA_WIDTH, 10, bits per pixel per channel.
- CHANNEL_NUM, 1, pixel channels in parallel.
- REG_WD, 32, width of register-side count inputs and outputs.

Ports:
- clk_sensor_pix  in  1  sensor pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_fval  in  1  sensor frame valid.
- i_lval  in  1  sensor line valid.
- iv_pix_data  in  DATA_WIDTH*CHANNEL_NUM  sensor pixel data.
- i_stream_enable  in  1  stream enable (se), level.
- i_acquisition_start  in  1  acquisition start (acq), level.
- i_encrypt_state  in  1  1 = encryption check passed.
- i_burst_mode  in  1  0 = continuous, 1 = burst.
- iv_burst_num  in  REG_WD  frames per burst.
- i_trigger  in  1  one-cycle pulse that starts a burst.
- o_fval  out  1  gated frame valid.
- o_lval  out  1  gated line valid.
- ov_pix_data  out  DATA_WIDTH*CHANNEL_NUM  gated pixel data.
- o_full_frame_state  out  1  1 while a frame is being forwarded.
- ov_frame_cnt  out  REG_WD  forwarded-frame counter.
- ov_burst_remain  out  REG_WD  frames left in the current burst.

Behaviour:
- Reset: all outputs, fval_d, state and internal registers go to 0; state = IDLE.
- Reset asserted mid-frame: o_fval drops immediately. After reset release the block waits for a fresh i_fval rise; the frame already in progress is never forwarded.
- Qualifier: en = i_stream_enable & i_acquisition_start & i_encrypt_state.
- Edge detection: fval_d is i_fval registered. rise = i_fval & ~fval_d; fall = ~i_fval & fval_d.
- State IDLE:
  - Continuous mode: go to ARMED when en = 1 and i_burst_mode = 0.
  - Burst mode: go to ARMED when en = 1, i_burst_mode = 1, i_trigger = 1 and iv_burst_num != 0. On that transition load burst_remain = iv_burst_num.
  - i_trigger while iv_burst_num = 0 is ignored.
  - Mode is latched into mode_l on every IDLE->ARMED transition. i_burst_mode changes after that have no effect until the block returns to IDLE.
- State ARMED:
  - en = 0: go to IDLE; burst_remain is cleared.
  - en = 1 and rise: go to PASS.
  - An ARMED entry during an active frame waits for the next rise, so partial frames are never forwarded.
- State PASS:
  - Ignores en and i_trigger until fall.
  - On fall, ov_frame_cnt increments, wrapping at 2^REG_WD.
  - If mode_l = burst, burst_remain decrements on fall.
  - Next state on fall:
    - en = 0: IDLE.
    - Burst mode and burst_remain was 1: IDLE.
    - Otherwise: ARMED.
- Output timing:
  - pass = (state == PASS) | (state == ARMED & en & rise).
  - o_fval, o_lval and ov_pix_data are registered. On each clock they load i_fval & pass, i_lval & pass & i_fval, and (pass ? iv_pix_data : 0) respectively.
  - Net effect: exactly 1 clock of latency, with output edges aligned to input edges plus 1.
- o_full_frame_state equals o_fval.
- ov_burst_remain equals burst_remain; it holds 0 in continuous mode.
- i_trigger received in ARMED or PASS is ignored: no reload, no extension of the burst.
- Simultaneous events:
  - en falling in the same cycle as rise (ARMED): the frame is not forwarded.
  - en rising in the same cycle as rise (IDLE): that frame is not forwarded. IDLE->ARMED costs one cycle, so the next frame is the first one forwarded.
- Implementation is a 3-state FSM plus two REG_WD counters and the data pipeline.

Test Plan:
- Continuous, se/acq/encrypt high before reset release, 64x64 frames → every frame forwarded with 1-clock latency. After 30 frames, ov_frame_cnt = 30 and output pixel data matches the input.
- Raise se in the middle of frame 3 → frame 3 is fully suppressed (o_fval stays 0). Frame 4 is forwarded complete, 64 lines.
- Drop acq in the middle of a forwarded frame → that frame completes all 64 lines, the FSM then goes to IDLE, and later frames are suppressed. ov_frame_cnt stops incrementing.
- Burst mode, iv_burst_num = 3, i_trigger pulse while fval is low → exactly 3 frames forwarded. ov_burst_remain steps 3→2→1→0 on each fall. A second trigger during frame 2 has no effect.
- Burst mode, iv_burst_num = 0 with a trigger → the FSM stays IDLE and nothing is forwarded. Encrypt low with se/acq high in continuous mode → nothing is forwarded.
- Assert reset_n low for 5 clocks mid-frame → o_fval goes low asynchronously and all counters read 0. Forwarding resumes at the next full frame after reset release.
